// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage controller around the 32-bit ALU.
// Holds the ALU opcode ("card") constants, the controller FSM state type and
// small helpers that classify an opcode.
package alu_pkg;

  localparam logic [4:0] CARD_ADD        = 5'd0;
  localparam logic [4:0] CARD_ADDC       = 5'd1;
  localparam logic [4:0] CARD_SUB        = 5'd2;
  localparam logic [4:0] CARD_SUBC       = 5'd3;
  localparam logic [4:0] CARD_RSUB       = 5'd4;
  localparam logic [4:0] CARD_RSUBC      = 5'd5;
  localparam logic [4:0] CARD_PASSA      = 5'd6;
  localparam logic [4:0] CARD_PASSB      = 5'd7;
  localparam logic [4:0] CARD_NOTA       = 5'd8;
  localparam logic [4:0] CARD_NOTB       = 5'd9;
  localparam logic [4:0] CARD_OR         = 5'd10;
  localparam logic [4:0] CARD_AND        = 5'd11;
  localparam logic [4:0] CARD_XNOR       = 5'd12;
  localparam logic [4:0] CARD_XOR        = 5'd13;
  localparam logic [4:0] CARD_NAND       = 5'd14;
  localparam logic [4:0] CARD_LAST_CARRY = 5'd5;
  localparam logic [4:0] CARD_LAST_VALID = 5'd14;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  // Cards above CARD_LAST_VALID are NOPs: no write-back, flags untouched.
  function automatic logic card_is_valid(input logic [4:0] card);
    return card <= CARD_LAST_VALID;
  endfunction

  // Only the arithmetic cards produce a meaningful carry/borrow.
  function automatic logic card_sets_carry(input logic [4:0] card);
    return card <= CARD_LAST_CARRY;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the execute controller.
// REG_N x DATA_W storage, r0 hardwired to zero.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset (clears all entries)
//   we_i/waddr_i/wdata_i  synchronous write port (writes to r0 are dropped)
//   raddr_a_i/rdata_a_o   combinational read port A
//   raddr_b_i/rdata_b_o   combinational read port B
//   dbg_addr_i/dbg_data_o combinational debug read port
module alu_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 8,
  parameter int unsigned REG_AW = $clog2(REG_N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [REG_N];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is masked on read so it stays zero regardless of storage contents.
  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller wrapped around the external combinational ALU.
// Accepts one register-format operation per valid/ready handshake, registers
// the ALU operands, then writes the ALU result back and updates the flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operation handshake (ready only in IDLE)
//   in_card, in_rd/rs/rt     opcode and register indices
//   in_use_imm, in_imm       immediate replaces rt as operand B
//   alu_a/b/cin/card         registered ALU inputs (cin mirrors flag_c)
//   alu_f/cout/zero          ALU results
//   out_valid/rd/data        one-cycle completion report
//   flag_c, flag_z           architectural carry and zero flags
//   dbg_addr, dbg_data       combinational register read for debug
module alu_exec_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 8,
  parameter int unsigned REG_AW = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_card,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [4:0]        alu_card,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_cout,
  input  logic              alu_zero,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import alu_pkg::*;

  state_e state_q, state_d;

  logic              accept;
  logic              in_exec;
  logic              wb_en;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [4:0]        alu_card_q, alu_card_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              out_valid_q, out_valid_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == StIdle);
    in_exec  = (state_q == StExec);
    accept   = in_ready && in_valid;
    wb_en    = in_exec && card_is_valid(alu_card_q);
  end

  // Datapath next state
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_card_d  = alu_card_q;
    rd_d        = rd_q;
    out_valid_d = 1'b0;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;

    if (accept) begin
      alu_a_d    = rdata_a;
      alu_b_d    = in_use_imm ? in_imm : rdata_b;
      alu_card_d = in_card;
      rd_d       = in_rd;
    end

    // The ALU has had the whole EXEC cycle to settle; commit at its closing edge.
    if (in_exec) begin
      out_valid_d = 1'b1;
      out_rd_d    = rd_q;
      if (card_is_valid(alu_card_q)) begin
        out_data_d = alu_f;
        flag_z_d   = alu_zero;
        if (card_sets_carry(alu_card_q)) begin
          flag_c_d = alu_cout;
        end
      end else begin
        out_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_card_q  <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_card_q  <= alu_card_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
    end
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (wb_en),
    .waddr_i    (rd_q),
    .wdata_i    (alu_f),
    .raddr_a_i  (in_rs),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (in_rt),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_card  = alu_card_q;
  assign alu_cin   = flag_c_q;
  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;

endmodule
